ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control/decode unit.
- Owns the PC register and runs a req/ack handshake with instruction memory.
- Presents one fetched instruction at a time, with a valid flag, to the decoder's Instruction input.
- Computes the next PC from the Branch/Jump/Imm/Target signals that control returns, plus the ALU Zero flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset and first address fetched.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- Imem_req  output  1  fetch request to instruction memory
- Imem_addr  output  32  word-aligned fetch address; equals PC
- Imem_ack  input  1  memory has Imem_rdata valid this cycle
- Imem_rdata  input  32  instruction word from memory
- Instruction  output  32  latched instruction to control/decoder
- Inst_valid  output  1  Instruction is current and executing this cycle
- PC  output  32  address of the current instruction
- Branch  input  1  beq-type branch from control, sampled while Inst_valid
- Zero  input  1  ALU zero flag, sampled while Inst_valid
- Jump  input  1  J-type from control, sampled while Inst_valid
- Imm  input  16  branch offset in words, from decoder
- Target  input  26  jump target field, from decoder
- Stall  input  1  hold the current instruction; do not advance

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low.
- Reset values while Reset=0:
  - state=IDLE, PC=RESET_PC, Instruction=32'h0 (nop), Inst_valid=0, Imem_req=0.
  - Takes effect immediately, independent of Clk.
- FSM states: IDLE, FETCH, EXEC.
- IDLE: unconditionally goes to FETCH on the first rising edge after Reset deasserts.
- FETCH:
  - Imem_req=1, Imem_addr=PC, Inst_valid=0.
  - Imem_addr is held stable while Imem_req=1.
  - On an edge with Imem_ack=1: Instruction<=Imem_rdata, go to EXEC.
  - Otherwise stay in FETCH (any number of wait states).
- EXEC:
  - Imem_req=0, Inst_valid=1. Instruction and PC are stable for the whole state.
  - Edge with Stall=1: remain in EXEC; PC and Instruction unchanged.
  - Edge with Stall=0: PC<=next_pc, go to FETCH.
- next_pc, evaluated combinationally from the inputs sampled in the EXEC cycle:
  - pc4 = PC+4, modulo 2^32.
  - If Jump=1: {pc4[31:28], Target, 2'b00}. Jump has priority over Branch.
  - Else if Branch=1 and Zero=1: pc4 + (sign_extend(Imm)<<2), modulo 2^32.
  - Else: pc4.
- Addressing:
  - PC[1:0] is always 00 by construction.
  - Wrap-around: 32'hFFFF_FFFC advances to 32'h0000_0000.
- Handshake details:
  - Imem_ack outside FETCH is ignored.
  - Imem_ack in the same cycle as the request is legal (zero-wait memory), giving a minimum of 2 cycles per instruction.
  - Imem_rdata is captured only on an acked FETCH edge.
- Reset mid-operation, in any state:
  - An outstanding request is abandoned; Imem_req drops asynchronously.
  - A late ack after reset release is ignored until FETCH is re-entered via IDLE.
- Branch, Zero, Jump, Imm and Target are don't-care outside EXEC.
- Outputs are glitch-free registered values, except Imem_req, Imem_addr and Inst_valid, which are decoded from registered state and PC.

Test Plan:
- Zero-wait fetch: release Reset; memory acks in the request cycle with 32'h2008_0005 -> Imem_addr=32'h0000_3000 on the first FETCH cycle; next cycle Instruction=32'h2008_0005 and Inst_valid=1; after EXEC, Imem_addr=32'h0000_3004.
- Wait states: Imem_ack delayed 3 cycles -> Imem_req held high and Imem_addr stable for 4 cycles; Inst_valid=0 throughout; Inst_valid asserts only on the cycle after the ack.
- Branch:
  - PC=32'h3010, Branch=1, Zero=1, Imm=16'hFFFC -> next PC=32'h3004.
  - Same with Zero=0 -> next PC=32'h3014.
  - Imm=16'h0003, Zero=1 -> next PC=32'h3020.
- Jump:
  - PC=32'h3020, Jump=1, Target=26'h0000C10 -> next PC=32'h0000_3040.
  - Jump=1 and Branch=1 with Zero=1 -> still 32'h0000_3040.
  - PC=32'hFFFF_FFFC with no branch or jump -> next PC=32'h0000_0000.
- Stall: Stall=1 for 2 EXEC cycles -> PC and Instruction unchanged, Imem_req=0; the fetch of PC+4 starts the cycle after Stall falls.
- Reset in flight: assert Reset during FETCH at PC=32'h3008 before ack -> Imem_req=0 immediately; PC=32'h3000, Inst_valid=0, Instruction=0; an ack arriving during reset has no effect; fetch restarts at 32'h3000.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface ifetch_unit_if;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;

    modport master (
        output Imem_req,
        output Imem_addr,
        input  Imem_ack,
        input  Imem_rdata
    );

    modport slave (
        input  Imem_req,
        input  Imem_addr,
        output Imem_ack,
        output Imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/ack bus and resolves branch/jump targets once the instruction has executed.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic         Clk,
    input  logic         Reset,
    ifetch_unit_if.master imem,
    output logic [31:0]  Instruction,
    output logic         Inst_valid,
    output logic [31:0]  PC,
    input  logic         Branch,
    input  logic         Zero,
    input  logic         Jump,
    input  logic [15:0]  Imm,
    input  logic [25:0]  Target,
    input  logic         Stall
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc4;
    logic [31:0] branch_offset;
    logic [31:0] next_pc;
    logic        req;
    logic        valid;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            Instruction <= 32'h0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem.Imem_ack) begin
                Instruction <= imem.Imem_rdata;
            end
            if (state == EXEC && !Stall) begin
                PC <= next_pc;
            end
        end
    end

    // Arithmetic wraps naturally at 32 bits, so FFFF_FFFC steps to 0.
    always_comb begin
        pc4           = PC + 32'd4;
        branch_offset = {{14{Imm[15]}}, Imm, 2'b00};
        next_pc       = pc4;
        if (Jump) begin
            next_pc = {pc4[31:28], Target, 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc4 + branch_offset;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                req = 1'b1;
                if (imem.Imem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                valid = 1'b1;
                if (!Stall) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem.Imem_req  = req;
    assign imem.Imem_addr = PC;
    assign Inst_valid     = valid;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit: hand-computed PC sequences through
// fetch wait states, branches, jumps, stalls and a mid-fetch reset.
module tb_ifetch_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instruction;
    logic        Inst_valid;
    logic [31:0] PC;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic [15:0] Imm;
    logic [25:0] Target;
    logic        Stall;

    int checkCount;
    int errorCount;

    ifetch_unit_if imem ();

    ifetch_unit #(
        .RESET_PC(32'h0000_3000)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .imem       (imem.master),
        .Instruction(Instruction),
        .Inst_valid (Inst_valid),
        .PC         (PC),
        .Branch     (Branch),
        .Zero       (Zero),
        .Jump       (Jump),
        .Imm        (Imm),
        .Target     (Target),
        .Stall      (Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge while in FETCH: memory answers in the request cycle.
    task automatic fetchZeroWait(input logic [31:0] word);
        imem.Imem_ack   = 1'b1;
        imem.Imem_rdata = word;
        @(negedge Clk);
        imem.Imem_ack   = 1'b0;
    endtask

    // Called at a falling edge while in EXEC: drive control for one edge, then clear it.
    task automatic applyStimulus(input logic br, input logic z, input logic j,
                                 input logic [15:0] im, input logic [25:0] tg);
        Branch = br;
        Zero   = z;
        Jump   = j;
        Imm    = im;
        Target = tg;
        @(negedge Clk);
        Branch = 1'b0;
        Zero   = 1'b0;
        Jump   = 1'b0;
        Imm    = 16'h0;
        Target = 26'h0;
    endtask

    task automatic runInstruction(input logic br, input logic z, input logic j,
                                  input logic [15:0] im, input logic [25:0] tg);
        fetchZeroWait(32'h0000_0000);
        applyStimulus(br, z, j, im, tg);
    endtask

    initial begin
        checkCount      = 0;
        errorCount      = 0;
        Reset           = 1'b0;
        Branch          = 1'b0;
        Zero            = 1'b0;
        Jump            = 1'b0;
        Imm             = 16'h0;
        Target          = 26'h0;
        Stall           = 1'b0;
        imem.Imem_ack   = 1'b0;
        imem.Imem_rdata = 32'h0;

        repeat (2) @(negedge Clk);
        checkOutput("reset_pc", PC, 32'h0000_3000);
        checkOutput("reset_instr", Instruction, 32'h0);
        checkOutput("reset_valid", {31'b0, Inst_valid}, 32'd0);
        checkOutput("reset_req", {31'b0, imem.Imem_req}, 32'd0);

        // Zero-wait fetch
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("zw_req", {31'b0, imem.Imem_req}, 32'd1);
        checkOutput("zw_addr", imem.Imem_addr, 32'h0000_3000);
        checkOutput("zw_valid_fetch", {31'b0, Inst_valid}, 32'd0);
        fetchZeroWait(32'h2008_0005);
        checkOutput("zw_instr", Instruction, 32'h2008_0005);
        checkOutput("zw_valid_exec", {31'b0, Inst_valid}, 32'd1);
        checkOutput("zw_req_exec", {31'b0, imem.Imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        checkOutput("zw_next_addr", imem.Imem_addr, 32'h0000_3004);

        // Wait states: ack on the fourth request cycle
        for (int i = 0; i < 4; i++) begin
            checkOutput("ws_req", {31'b0, imem.Imem_req}, 32'd1);
            checkOutput("ws_addr", imem.Imem_addr, 32'h0000_3004);
            checkOutput("ws_valid", {31'b0, Inst_valid}, 32'd0);
            if (i == 3) begin
                imem.Imem_ack   = 1'b1;
                imem.Imem_rdata = 32'hAC01_0004;
            end
            @(negedge Clk);
        end
        imem.Imem_ack = 1'b0;
        checkOutput("ws_valid_after", {31'b0, Inst_valid}, 32'd1);
        checkOutput("ws_instr", Instruction, 32'hAC01_0004);

        // Climb to 3010
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        runInstruction(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        runInstruction(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        checkOutput("climb_addr", imem.Imem_addr, 32'h0000_3010);

        runInstruction(1'b1, 1'b1, 1'b0, 16'hFFFC, 26'h0);
        checkOutput("br_taken_back", imem.Imem_addr, 32'h0000_3004);

        runInstruction(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        runInstruction(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        runInstruction(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        checkOutput("climb_addr2", imem.Imem_addr, 32'h0000_3010);
        runInstruction(1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0);
        checkOutput("br_not_taken", imem.Imem_addr, 32'h0000_3014);

        runInstruction(1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0);
        checkOutput("br_back_3010", imem.Imem_addr, 32'h0000_3010);
        runInstruction(1'b1, 1'b1, 1'b0, 16'h0003, 26'h0);
        checkOutput("br_fwd", imem.Imem_addr, 32'h0000_3020);

        runInstruction(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000C10);
        checkOutput("jump", imem.Imem_addr, 32'h0000_3040);
        runInstruction(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000C08);
        checkOutput("jump_back", imem.Imem_addr, 32'h0000_3020);
        runInstruction(1'b1, 1'b1, 1'b1, 16'hFFFC, 26'h0000C10);
        checkOutput("jump_priority", imem.Imem_addr, 32'h0000_3040);

        // 3044 - 0x3048 wraps below zero to FFFF_FFFC, then PC+4 wraps to 0
        runInstruction(1'b1, 1'b1, 1'b0, 16'hF3EE, 26'h0);
        checkOutput("br_wrap_neg", imem.Imem_addr, 32'hFFFF_FFFC);
        runInstruction(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        checkOutput("pc_wrap", imem.Imem_addr, 32'h0000_0000);

        // Stall for two EXEC edges
        fetchZeroWait(32'h8C01_0000);
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            checkOutput("stall_pc", PC, 32'h0000_0000);
            checkOutput("stall_instr", Instruction, 32'h8C01_0000);
            checkOutput("stall_req", {31'b0, imem.Imem_req}, 32'd0);
            checkOutput("stall_valid", {31'b0, Inst_valid}, 32'd1);
        end
        Stall = 1'b0;
        @(negedge Clk);
        checkOutput("stall_release_req", {31'b0, imem.Imem_req}, 32'd1);
        checkOutput("stall_release_addr", imem.Imem_addr, 32'h0000_0004);

        // Reset while a fetch of 3008 is outstanding
        runInstruction(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000C02);
        checkOutput("rst_pre_addr", imem.Imem_addr, 32'h0000_3008);
        checkOutput("rst_pre_req", {31'b0, imem.Imem_req}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("rst_async_req", {31'b0, imem.Imem_req}, 32'd0);
        checkOutput("rst_async_pc", PC, 32'h0000_3000);
        checkOutput("rst_async_valid", {31'b0, Inst_valid}, 32'd0);
        checkOutput("rst_async_instr", Instruction, 32'h0);
        imem.Imem_ack   = 1'b1;
        imem.Imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge Clk);
        checkOutput("rst_ack_ignored", Instruction, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("late_ack_instr", Instruction, 32'h0);
        checkOutput("late_ack_valid", {31'b0, Inst_valid}, 32'd0);
        checkOutput("restart_addr", imem.Imem_addr, 32'h0000_3000);
        checkOutput("restart_req", {31'b0, imem.Imem_req}, 32'd1);
        imem.Imem_rdata = 32'h1234_5678;
        @(negedge Clk);
        imem.Imem_ack = 1'b0;
        checkOutput("restart_instr", Instruction, 32'h1234_5678);
        checkOutput("restart_valid", {31'b0, Inst_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
